dec16_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-way one-hot select resource among 16 requesters.
- Picks one requester, drives its registered 4-bit index and the matching one-hot 4-to-16 decoded grant, and holds the grant until the owner releases.
- Sits in front of any 16-line one-hot select path. It turns the team's combinational 4-to-16 decode into a sequenced, fairly shared resource with an enable gate.

---
 rtl/dec16_arb_pkg.sv | 23 ++
 rtl/rr_pick16.sv | 35 +++
 rtl/dec16_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_dec16_rr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec16_arb_pkg.sv
// Shared constants, state encoding and 4-to-16 decode for the
// dec16 round-robin arbiter.
package dec16_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot16(
        input logic [IDX_W-1:0] idx
    );
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority pick: first set request bit at or after ptr,
// wrapping modulo 16.
module rr_pick16
    import dec16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] pick
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any  = |req;
    assign pick = ptr + off;

endmodule

// File: rtl/dec16_rr_arbiter.sv
// 16-way round-robin arbiter with registered one-hot grant.
// Optional hold timeout enabled by DEC16_ARB_TIMEOUT_EN.
module dec16_rr_arbiter
    import dec16_arb_pkg::*;
`ifdef DEC16_ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 15
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
`ifdef DEC16_ARB_TIMEOUT_EN
    ,
    output logic             tmo
`endif
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             vld_q, vld_d;

    logic [N_REQ-1:0] req_eff;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

`ifdef DEC16_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] blk_q, blk_d;
    logic             tmo_q, tmo_d;
    logic             hold_done;

    // A timed-out owner stays masked until it drops its request.
    assign req_eff   = req & ~blk_q;
    assign hold_done = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    assign req_eff   = req;
`endif

    rr_pick16 u_pick (
        .req  (req_eff),
        .ptr  (ptr_q),
        .any  (pick_any),
        .pick (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
`ifdef DEC16_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        blk_d   = blk_q & req;
`endif
        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    idx_d   = pick_idx;
                    gnt_d   = onehot16(pick_idx);
                    vld_d   = 1'b1;
                    state_d = GRANT;
`ifdef DEC16_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!en || !req[idx_q]) begin
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + IDX_W'(1);
                    state_d = IDLE;
                end
`ifdef DEC16_ARB_TIMEOUT_EN
                else if (hold_done) begin
                    gnt_d        = '0;
                    vld_d        = 1'b0;
                    ptr_d        = idx_q + IDX_W'(1);
                    state_d      = IDLE;
                    tmo_d        = 1'b1;
                    blk_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

`ifdef DEC16_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            blk_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`endif

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;

endmodule

// File: tb/tb_dec16_rr_arbiter.sv
// Scoreboard bench for dec16_rr_arbiter: stimulus queues expected
// grant indices, a negedge monitor pops and compares on each new grant.
module tb_dec16_rr_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [15:0] req   = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
`ifdef DEC16_ARB_TIMEOUT_EN
    logic        tmo;
`endif

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [3:0]  exp_q[$];
    logic        prev_vld = 1'b0;

    always #5 clk = ~clk;

`ifdef DEC16_ARB_TIMEOUT_EN
    dec16_rr_arbiter #(.MAX_HOLD(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );
`else
    dec16_rr_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    always @(negedge clk) begin
        logic       inv_ok;
        logic [3:0] e;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            inv_ok = ($countones(gnt) <= 1) &&
                     (gnt_vld == (gnt != 16'h0)) &&
                     (!gnt_vld || gnt == (16'h1 << gnt_idx));
            chk("invariant", {31'b0, inv_ok}, 32'h1);
            if (gnt_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_grant: got idx %0d want none",
                             gnt_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_idx", gnt_idx, e);
                    chk("grant_onehot", gnt, 32'h1 << e);
                end
            end
            prev_vld = gnt_vld;
        end
    end

    task automatic wait_vld(input int k);
        bit got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            got = gnt_vld;
        end
        if (!got) begin
            tot_cnt++;
            $display("FAIL wait_grant: got no grant want idx %0d", k);
        end
    endtask

    // Owner k keeps its grant for 'hold' cycles, then drops its bit;
    // req becomes nxt on the release edge.
    task automatic release_own(input int k, input int hold,
                               input logic [15:0] nxt);
        repeat (hold - 1) @(posedge clk);
        #1 req[k] = 1'b0;
        @(posedge clk);
        #1 req = nxt;
        @(negedge clk);
        chk("dead_cycle", gnt_vld, 0);
    endtask

    task automatic serve(input int k, input int hold,
                         input logic [15:0] nxt);
        exp_q.push_back(4'(k));
        wait_vld(k);
        release_own(k, hold, nxt);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        en  = 1'b0;
        req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drive(input logic e, input logic [15:0] r);
        @(posedge clk);
        #1;
        en  = e;
        req = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_vld", gnt_vld, 0);
        chk("rst_idx", gnt_idx, 0);
        #2 rst_n = 1'b1;

        // Single requester, latency and release
        drive(1'b1, 16'h0100);
        exp_q.push_back(4'd8);
        @(negedge clk);
        chk("latency_pre", gnt_vld, 0);
        wait_vld(8);
        chk("single_gnt", gnt, 16'h0100);
        drive(1'b1, 16'h0000);
        @(negedge clk);
        chk("hold_to_edge", gnt, 16'h0100);
        @(negedge clk);
        chk("single_release", gnt, 0);
        chk("idx_kept", gnt_idx, 8);
        drive(1'b1, 16'h0300);
        serve(9, 1, 16'h0000);

        // Round robin with all requesting
        apply_reset();
        drive(1'b1, 16'hFFFF);
        for (int i = 0; i <= 16; i++) begin
            serve(i % 16, 2, (i == 16) ? 16'h0000 : 16'hFFFF);
        end

        // Wrap and priority from ptr=14
        drive(1'b1, 16'h2000);
        serve(13, 1, 16'h8011);
        serve(15, 1, 16'h0011);
        serve(0, 1, 16'h0010);
        serve(4, 1, 16'h0000);

        // Enable gating
        drive(1'b0, 16'h0008);
        repeat (3) @(negedge clk);
        chk("en_block", gnt_vld, 0);
        drive(1'b1, 16'h0008);
        exp_q.push_back(4'd3);
        @(negedge clk);
        chk("en_pre", gnt_vld, 0);
        @(negedge clk);
        chk("en_rise", gnt, 16'h0008);
        drive(1'b0, 16'h0008);
        @(negedge clk);
        @(negedge clk);
        chk("en_drop", gnt, 0);
        drive(1'b1, 16'h0018);
        serve(4, 1, 16'h0000);

        // Asynchronous reset mid-grant
        drive(1'b1, 16'h0021);
        exp_q.push_back(4'd5);
        wait_vld(5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_vld", gnt_vld, 0);
        chk("midrst_idx", gnt_idx, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.push_back(4'd0);
        wait_vld(0);
        release_own(0, 1, 16'h0000);

`ifdef DEC16_ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD=3 cycles
        apply_reset();
        drive(1'b1, 16'h0003);
        exp_q.push_back(4'd0);
        wait_vld(0);
        @(negedge clk);
        chk("tmo_hold2", gnt_vld, 1);
        @(negedge clk);
        chk("tmo_hold3", gnt_vld, 1);
        chk("tmo_low", tmo, 0);
        exp_q.push_back(4'd1);
        @(negedge clk);
        chk("tmo_release", gnt_vld, 0);
        chk("tmo_pulse", tmo, 1);
        wait_vld(1);
        chk("tmo_pulse_end", tmo, 0);
        drive(1'b1, 16'h0000);
        repeat (2) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
